// File: rtl/seg7_scan_if.sv
// Bus between a host and the 7-segment scan controller: value loading in,
// shared-decoder nibble and anode enables out.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4
);
  // load is a single-cycle strobe with no ready: the controller accepts it
  // on every edge it is high, and a later strobe simply replaces the value.
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    lz_en;
  logic [3:0]              bcd;
  logic [NUM_DIGITS-1:0]   an;
  logic                    upd_pending;
  logic                    frame_done;

  modport master (
    output load, value_in, lz_en,
    input  bcd, an, upd_pending, frame_done
  );

  modport slave (
    input  load, value_in, lz_en,
    output bcd, an, upd_pending, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan of NUM_DIGITS common-anode digits through one shared
// BCD decoder, with a blanking gap per digit and frame-aligned value updates.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst,
  seg7_scan_if.slave bus,
  output logic       state_dbg
);
  localparam int CMAX = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int VW   = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

  state_t          state, nx_state;
  logic [CW-1:0]   cnt, nx_cnt;
  logic [IW-1:0]   idx, nx_idx;
  logic [VW-1:0]   disp, nx_disp;
  logic [VW-1:0]   pend, nx_pend;
  logic            upd, nx_upd;
  logic            boundary;
  logic            nonzero_above;
  logic            suppress;
  logic [NUM_DIGITS-1:0] nx_an;
  logic [3:0]      nx_bcd;

  assign state_dbg = state;

  always_comb begin
    nx_state = state;
    nx_cnt   = cnt + 1'b1;
    nx_idx   = idx;
    nx_disp  = disp;
    nx_pend  = pend;
    nx_upd   = upd;
    boundary = 1'b0;
    if (bus.load) begin
      nx_pend = bus.value_in;
      nx_upd  = 1'b1;
    end
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          nx_state = SHOW;
          nx_cnt   = '0;
        end
      end
      SHOW: begin
        if (cnt == TICK_LAST) begin
          nx_state = BLANK;
          nx_cnt   = '0;
          if (idx == IDX_LAST) begin
            nx_idx   = '0;
            boundary = 1'b1;
          end else begin
            nx_idx = idx + 1'b1;
          end
        end
      end
      default: nx_state = BLANK;
    endcase
    // A strobe landing on the boundary edge bypasses pend so it is not delayed a frame.
    if (boundary) begin
      if (bus.load) begin
        nx_disp = bus.value_in;
        nx_upd  = 1'b0;
      end else if (upd) begin
        nx_disp = pend;
        nx_upd  = 1'b0;
      end
    end
  end

  // Outputs are decoded from the next-state values so they register on the same edge.
  always_comb begin
    nonzero_above = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IW'(k) >= nx_idx && nx_disp[4*k +: 4] != 4'h0) nonzero_above = 1'b1;
    end
    suppress = bus.lz_en && (nx_idx != '0) && !nonzero_above;
    nx_an    = '1;
    nx_bcd   = 4'hF;
    if (nx_state == SHOW) begin
      nx_an[nx_idx] = 1'b0;
      if (!suppress) nx_bcd = nx_disp[4*nx_idx +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= BLANK;
      cnt             <= '0;
      idx             <= '0;
      disp            <= '0;
      pend            <= '0;
      upd             <= 1'b0;
      bus.an          <= '1;
      bus.bcd         <= 4'hF;
      bus.upd_pending <= 1'b0;
      bus.frame_done  <= 1'b0;
    end else begin
      state           <= nx_state;
      cnt             <= nx_cnt;
      idx             <= nx_idx;
      disp            <= nx_disp;
      pend            <= nx_pend;
      upd             <= nx_upd;
      bus.an          <= nx_an;
      bus.bcd         <= nx_bcd;
      bus.upd_pending <= nx_upd;
      bus.frame_done  <= boundary;
    end
  end
endmodule
